// File: rtl/fb_scanout.sv
// fb_scanout: read-side scanout of a 128x32-byte, 1-bpp framebuffer.
// The block fetches one byte ahead of the beam and shifts it out MSB-first.
// It drives a registered 3-bit colour, line-doubled, with a per-frame vertical scroll.
module fb_scanout #(
   parameter int         H_ACTIVE = 256,
   parameter int         H_TOTAL  = 309,
   parameter int         V_ACTIVE = 240,
   parameter int         V_TOTAL  = 262,
   parameter logic [2:0] FG       = 3'b111,
   parameter logic [2:0] BG       = 3'b000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        display_on,
   input  logic [8:0]  hpos,
   input  logic [8:0]  vpos,
   input  logic [6:0]  scroll_y,
   output logic        rd_en,
   output logic [11:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic [2:0]  rgb
);

   localparam logic [8:0] H_ACT       = 9'(H_ACTIVE);
   localparam logic [8:0] H_FETCH_END = 9'(H_ACTIVE - 8);
   localparam logic [8:0] H_LOAD_END  = 9'(H_ACTIVE - 1);
   localparam logic [8:0] H_LS_FETCH  = 9'(H_TOTAL - 3);
   localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_ACT       = 9'(V_ACTIVE);
   localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);

   logic [6:0] scroll_q;
   logic [7:0] sh;
   logic [8:0] next_v;
   logic       fetch_line;
   logic       fetch_start;
   logic       load_sh;
   logic       scroll_ld;

   // Each framebuffer row is shown on two lines, offset by the scroll value.
   // The sum wraps modulo 128.
   function automatic logic [6:0] row_of(input logic [8:0] v, input logic [6:0] s);
      return v[7:1] + s;
   endfunction

   // Decode beam position into fetch, load and scroll-latch strobes.
   always_comb begin
      next_v      = (vpos == V_LAST) ? 9'd0 : vpos + 9'd1;
      fetch_line  = (hpos[2:0] == 3'd5) && (hpos < H_FETCH_END);
      fetch_start = (hpos == H_LS_FETCH);
      load_sh     = ((hpos[2:0] == 3'd7) && (hpos < H_LOAD_END)) || (hpos == H_LAST);
      scroll_ld   = (vpos == V_ACT) && (hpos == 9'd0);
   end

   // Latch the scroll once per frame, at the start of vertical blanking.
   // This keeps the picture from tearing within a frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         scroll_q <= 7'd0;
      else if (scroll_ld)
         scroll_q <= scroll_y;
   end

   // Issue a single-cycle read: either the next group on this line or group 0 of the next line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_en   <= 1'b0;
         rd_addr <= 12'd0;
      end else if (fetch_line) begin
         rd_en   <= 1'b1;
         rd_addr <= {row_of(vpos, scroll_q), hpos[7:3] + 5'd1};
      end else if (fetch_start) begin
         rd_en   <= 1'b1;
         rd_addr <= {row_of(next_v, scroll_q), 5'd0};
      end else begin
         rd_en   <= 1'b0;
      end
   end

   // Load the fetched byte just before its group starts; otherwise shift left, filling with zeros.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sh <= 8'd0;
      else if (load_sh)
         sh <= rd_data;
      else
         sh <= {sh[6:0], 1'b0};
   end

   // Register the current pixel colour; blank outside the active area.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rgb <= 3'b000;
      else if (display_on && (hpos < H_ACT))
         rgb <= sh[7] ? FG : BG;
      else
         rgb <= 3'b000;
   end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: the bench drives the beam itself, models the framebuffer RAM,
// and checks fetch strobes, addresses and pixel colours.
module tb_fb_scanout;

   localparam int H_ACTIVE = 256;
   localparam int H_TOTAL  = 309;
   localparam int V_ACTIVE = 240;
   localparam int V_TOTAL  = 262;

   logic        clk = 1'b0;
   logic        reset;
   logic        display_on;
   logic [8:0]  hpos;
   logic [8:0]  vpos;
   logic [6:0]  scroll_y;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic [2:0]  rgb;

   logic [7:0]  mem [4096];

   int checks = 0;
   int errors = 0;
   int bh, bv;   // beam position presented to the DUT
   int ph, pv;   // beam position sampled on the most recent edge

   fb_scanout dut (
      .clk        (clk),
      .reset      (reset),
      .display_on (display_on),
      .hpos       (hpos),
      .vpos       (vpos),
      .scroll_y   (scroll_y),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rgb        (rgb)
   );

   always #5 clk = ~clk;

   // Synchronous-read framebuffer model.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic drive_beam();
      hpos       = 9'(bh);
      vpos       = 9'(bv);
      display_on = (bh < H_ACTIVE) && (bv < V_ACTIVE);
   endtask

   task automatic set_beam(input int h, input int v);
      bh = h;
      bv = v;
      drive_beam();
   endtask

   // One pixel clock: record the sampled position, then advance the beam.
   task automatic tick();
      @(posedge clk);
      #1;
      ph = bh;
      pv = bv;
      if (bh == H_TOTAL - 1) begin
         bh = 0;
         bv = (bv == V_TOTAL - 1) ? 0 : bv + 1;
      end else begin
         bh = bh + 1;
      end
      drive_beam();
   endtask

   task automatic wait_fetch(input int bound, output bit got);
      got = 1'b0;
      for (int k = 0; k < bound && !got; k++) begin
         tick();
         if (rd_en === 1'b1) got = 1'b1;
      end
   endtask

   task automatic fill_mem(input logic [7:0] b);
      for (int i = 0; i < 4096; i++) mem[i] = b;
   endtask

   task automatic test_reset();
      bit got;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
         checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL reset_rd_addr got %h want 000", rd_addr); end
         checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL reset_rgb got %0d want 0", rgb); end
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL idle_rd_en got %b want 0", rd_en); end
         checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL idle_rgb got %0d want 0", rgb); end
      end
      set_beam(300, 0);
      wait_fetch(20, got);
      checks++; if (!got) begin errors++; $display("FAIL first_fetch timeout got none want pulse"); end
      checks++; if (ph != 306) begin errors++; $display("FAIL first_fetch_h got %0d want 306", ph); end
      checks++; if (rd_addr !== 12'h000) begin errors++; $display("FAIL first_fetch_addr got %h want 000", rd_addr); end
   endtask

   task automatic test_all_ff();
      logic [2:0] exp;
      fill_mem(8'hFF);
      set_beam(300, 10);
      for (int k = 0; k < 9 + H_TOTAL; k++) begin
         tick();
         exp = (pv == 11 && ph < H_ACTIVE) ? 3'd7 : 3'd0;
         checks++; if (rgb !== exp) begin errors++; $display("FAIL ff_rgb v%0d h%0d got %0d want %0d", pv, ph, rgb, exp); end
      end
      set_beam(0, 245);
      for (int k = 0; k < H_TOTAL; k++) begin
         tick();
         checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL blank_rgb v%0d h%0d got %0d want 0", pv, ph, rgb); end
      end
   endtask

   task automatic test_pattern_80();
      logic [2:0]  exp_rgb;
      logic        exp_en;
      logic [11:0] exp_addr;
      int          pulses;
      fill_mem(8'h80);
      pulses = 0;
      set_beam(300, 20);
      for (int k = 0; k < 9 + H_TOTAL; k++) begin
         tick();
         if (pv == 20) begin
            exp_rgb  = 3'd0;
            exp_en   = (ph == 306);
            exp_addr = 12'h140;
         end else begin
            exp_rgb  = (ph < H_ACTIVE && ph % 8 == 0) ? 3'd7 : 3'd0;
            exp_en   = (ph % 8 == 5 && ph < 248) || ph == 306;
            exp_addr = (ph == 306) ? 12'h160 : 12'(10 * 32 + ph / 8 + 1);
            if (rd_en === 1'b1) pulses++;
         end
         checks++; if (rgb !== exp_rgb) begin errors++; $display("FAIL p80_rgb v%0d h%0d got %0d want %0d", pv, ph, rgb, exp_rgb); end
         checks++; if (rd_en !== exp_en) begin errors++; $display("FAIL p80_rd_en v%0d h%0d got %b want %b", pv, ph, rd_en, exp_en); end
         if (exp_en) begin
            checks++; if (rd_addr !== exp_addr) begin errors++; $display("FAIL p80_addr v%0d h%0d got %h want %h", pv, ph, rd_addr, exp_addr); end
         end
      end
      checks++; if (pulses != 32) begin errors++; $display("FAIL p80_pulse_count got %0d want 32", pulses); end
   endtask

   task automatic test_row_map();
      bit got;
      set_beam(0, 2);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'h021) begin errors++; $display("FAIL row_v2 got %h want 021", rd_addr); end
      set_beam(0, 3);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'h021) begin errors++; $display("FAIL row_v3 got %h want 021", rd_addr); end
      set_beam(300, 260);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'h040) begin errors++; $display("FAIL row_v260_ls got %h want 040", rd_addr); end
      set_beam(300, 261);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'h000) begin errors++; $display("FAIL row_v261_ls got %h want 000", rd_addr); end
   endtask

   task automatic test_scroll();
      bit got;
      set_beam(0, 100);
      scroll_y = 7'd127;
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'h641) begin errors++; $display("FAIL scroll_midframe got %h want 641", rd_addr); end
      set_beam(300, 239);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'hF00) begin errors++; $display("FAIL scroll_v239_ls got %h want F00", rd_addr); end
      wait_fetch(20, got);
      checks++; if (!got || pv != 240 || rd_addr !== 12'hEE1) begin errors++; $display("FAIL scroll_v240 got %h want EE1", rd_addr); end
      set_beam(300, 261);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'hFE0) begin errors++; $display("FAIL scroll_line0_ls got %h want FE0", rd_addr); end
      wait_fetch(20, got);
      checks++; if (!got || pv != 0 || rd_addr !== 12'hFE1) begin errors++; $display("FAIL scroll_line0 got %h want FE1", rd_addr); end
      set_beam(0, 2);
      wait_fetch(10, got);
      checks++; if (!got || rd_addr !== 12'h001) begin errors++; $display("FAIL scroll_line2 got %h want 001", rd_addr); end
   endtask

   task automatic test_reset_midline();
      logic [7:0] pat;
      logic [2:0] exp;
      bit         seen;
      pat = 8'hA5;
      fill_mem(pat);
      set_beam(300, 30);
      for (int k = 0; k < 9 + 100; k++) tick();
      reset = 1'b1;
      #1;
      checks++; if (rgb !== 3'd0 || rd_en !== 1'b0) begin errors++; $display("FAIL midreset_async got rgb %0d en %b want 0 0", rgb, rd_en); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (rgb !== 3'd0) begin errors++; $display("FAIL midreset_rgb h%0d got %0d want 0", ph, rgb); end
         checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL midreset_rd_en h%0d got %b want 0", ph, rd_en); end
      end
      reset = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 206; k++) begin
         tick();
         if (ph == 306) begin
            seen = 1'b1;
            checks++; if (rd_en !== 1'b1 || rd_addr !== 12'h200) begin errors++; $display("FAIL postreset_ls got en %b addr %h want 1 200", rd_en, rd_addr); end
         end
      end
      checks++; if (!seen) begin errors++; $display("FAIL postreset_ls_reached got none want h306"); end
      for (int k = 0; k < H_TOTAL; k++) begin
         tick();
         exp = (ph < H_ACTIVE && pat[7 - (ph % 8)]) ? 3'd7 : 3'd0;
         checks++; if (rgb !== exp) begin errors++; $display("FAIL postreset_rgb v%0d h%0d got %0d want %0d", pv, ph, rgb, exp); end
      end
   endtask

   initial begin
      reset    = 1'b1;
      scroll_y = 7'd0;
      fill_mem(8'h00);
      set_beam(0, 0);
      test_reset();
      test_all_ff();
      test_pattern_80();
      test_row_map();
      test_scroll();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer read-side scanout for the 8-bit video pipeline. Reads the 4096-byte 1-bpp framebuffer that the voxel renderer writes through `we`/`addr`/`ram_d`. Fetches one byte per 8 pixels ahead of the beam, serialises it MSB-first, and drives a registered 3-bit colour for the video output. Vertical resolution is line-doubled, and a per-frame vertical scroll is applied.

## Interface
- `H_ACTIVE`, 256: visible pixels per line (multiple of 8, ≤256).
- `H_TOTAL`, 309: hpos wraps after H_TOTAL-1.
- `V_ACTIVE`, 240: visible lines.
- `V_TOTAL`, 262: vpos wraps after V_TOTAL-1.
- `FG`, 3'b111: colour for a set bit.
- `BG`, 3'b000: colour for a clear bit in the active area.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `display_on` in 1: beam in active area.
- `hpos` in 9: beam column, from the video sync generator.
- `vpos` in 9: beam line.
- `scroll_y` in 7: vertical scroll in framebuffer rows; latched once per frame.
- `rd_en` out 1: read strobe to the framebuffer's synchronous read port.
- `rd_addr` out 12: byte address, {row[6:0], group[4:0]}.
- `rd_data` in 8: RAM output, valid the cycle after the RAM samples `rd_addr`/`rd_en`.
- `rgb` out 3: registered pixel colour.

## Operation
- Framebuffer organisation:
  - 128 rows × 32 bytes.
  - Byte bit 7 is the leftmost pixel of its 8-pixel group.
- Row for line v: row = ((v >> 1) + scroll_q) mod 128, computed in 7 bits with the carry discarded.
- `scroll_q` loads `scroll_y` on the edge sampling vpos==V_ACTIVE && hpos==0. It holds otherwise, so scroll changes never tear within a frame.
- In-line fetch: on the edge sampling hpos%8==5 && hpos < H_ACTIVE-8:
  - `rd_addr` <= {row(vpos), (hpos>>3)+1}
  - `rd_en` <= 1
- Line-start fetch: on the edge sampling hpos==H_TOTAL-3:
  - `rd_addr` <= {row(nv), 0}, where nv = (vpos==V_TOTAL-1) ? 0 : vpos+1.
  - `rd_en` <= 1
- `rd_en` is 0 on all other edges. There is exactly one pulse per fetch.
- Shift register `sh`[7:0]:
  - Loads `rd_data` on the edge sampling (hpos%8==7 && hpos < H_ACTIVE-1) or hpos==H_TOTAL-1.
  - Otherwise shifts left, filling 0.
- Colour output, evaluated at each edge:
  - `rgb` <= (display_on && hpos < H_ACTIVE) ? (sh[7] ? FG : BG) : 3'b000.
- Fetches continue during vertical blanking. Harmless, and keeps the line-start path uniform.
- Reset values:
  - `rd_en`=0, `rd_addr`=0, `rgb`=0.
  - `sh`=0, `scroll_q`=0.
- Reset mid-line: all outputs take reset values immediately. The first valid pixels follow the next line-start fetch. No partial-line recovery is attempted.

## Timing
- Read path: fetch issued on the edge sampling hpos=h. The RAM samples on the edge sampling h+1. `rd_data` is valid during the cycle hpos=h+2 and is loaded into `sh` on that edge.
- During the cycle hpos=8k+j, `sh`[7] holds bit (7-j) of group k.
- Pixel latency: `rgb` during the cycle hpos=h+1 shows pixel h. The sync generator delays hsync/vsync by 1 cycle to match.
- Group 0 of a line is fetched 3 cycles before hpos wraps. This requires H_TOTAL ≥ H_ACTIVE+3.
- No fetch is issued for a group beyond 31. The last group's data shifts out and zeros follow.
- Fetch and load never coincide on the same edge, and at most one fetch is in flight.

## Test plan
- Reset and clock freely with all inputs 0: `rd_en`, `rd_addr` and `rgb` stay 0 while reset is held; the first `rd_en` pulse occurs at hpos=H_TOTAL-3 with `rd_addr`=0x000.
- RAM all 0xFF, scroll 0: every active pixel shows `rgb`=7, one cycle late; during hpos≥H_ACTIVE or blanking, `rgb`=0.
- Byte 0x80 at every address: `rgb`=7 at cycles hpos=1,9,17,…,249 of each active line and 0 elsewhere; `rd_en` pulses at hpos=5,13,…,245 with group fields 1…31.
- Row mapping: vpos=2 vs vpos=3 must both fetch row 1 (`rd_addr`[11:5]=1); the line-start fetch at vpos=261 targets row 0.
- Scroll: with scroll_y=127 set mid-frame, the change takes effect only after vpos=V_ACTIVE; the next frame's line 0 fetches row 127 and line 2 fetches row 0 (wrap).
- Assert reset at hpos=100 for 3 cycles: `rgb` and `rd_en` are 0 during reset; no `rd_en` until hpos=H_TOTAL-3; the next line's pixels are correct.
